// File: rtl/host_interface_burst.sv
// Host-side burst register interface: endpoint/register set-up, burst writes
// and prefetched burst reads with a read-return FIFO hiding device latency.
module host_interface_burst #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int LW       = 16,
    parameter int FIFO_AW  = 2,
    parameter int AUTO_INC = 1
) (
    input  logic          if_clock,
    input  logic          reset,
    input  logic [3:0]    state,
    input  logic [2:0]    ctl,
    input  logic [DW-1:0] hi_data_in,
    output logic [DW-1:0] hi_data_out,
    output logic          hi_data_oe,
    output logic          rdy,
    output logic          overrun,
    output logic [AW-1:0] di_ep_addr,
    output logic [AW-1:0] di_reg_addr,
    output logic [DW-1:0] di_reg_data_in,
    output logic          di_write,
    output logic          di_read,
    output logic          di_reset,
    input  logic          di_ready,
    input  logic          di_read_valid,
    input  logic [DW-1:0] di_reg_data_out
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [3:0] OP_SETEP    = 4'd1;
    localparam logic [3:0] OP_SETREG   = 4'd2;
    localparam logic [3:0] OP_SETLEN   = 4'd3;
    localparam logic [3:0] OP_RDDATA   = 4'd4;
    localparam logic [3:0] OP_DEVRESET = 4'd5;
    localparam logic [3:0] OP_WRDATA   = 4'd7;

    logic [3:0]         st_q;
    logic [3:0]         st_prev;
    logic               stb_q;
    logic [DW-1:0]      din_q;

    logic [LW-1:0]      len_q;
    logic [LW-1:0]      remaining;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      out_nxt;
    logic [CW-1:0]      count;
    logic [CW:0]        inflight;
    logic               discard;

    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [DW-1:0]      mem [DEPTH];

    logic change;
    logic act;
    logic is_ep;
    logic is_reg;
    logic is_len;
    logic is_rd;
    logic is_wr;
    logic wr_go;
    logic wr_drop;
    logic pop;
    logic rd_under;
    logic issue;
    logic ret;
    logic push;

    logic unused_ctl;
    assign unused_ctl = ^{ctl[2], ctl[0]};

    always_ff @(posedge if_clock or posedge reset) begin
        if (reset) begin
            st_q    <= '0;
            st_prev <= '0;
            stb_q   <= 1'b0;
            din_q   <= '0;
        end else begin
            st_q    <= state;
            st_prev <= st_q;
            stb_q   <= ctl[1];
            din_q   <= hi_data_in;
        end
    end

    // The cycle in which a new state code is first seen performs no opcode work.
    assign change = (st_q != st_prev);
    assign act    = !change;

    assign is_ep  = act && (st_q == OP_SETEP);
    assign is_reg = act && (st_q == OP_SETREG);
    assign is_len = act && (st_q == OP_SETLEN);
    assign is_rd  = act && (st_q == OP_RDDATA);
    assign is_wr  = act && (st_q == OP_WRDATA);

    assign wr_go    = is_wr && stb_q && di_ready;
    assign wr_drop  = is_wr && stb_q && !di_ready;
    assign pop      = is_rd && stb_q && (count != '0);
    assign rd_under = is_rd && stb_q && (count == '0);

    assign inflight = {1'b0, outstanding} + {1'b0, count};
    assign issue    = is_rd && !discard && (remaining != '0)
                      && di_ready && (int'(inflight) < DEPTH);
    assign ret      = di_read_valid && (outstanding != '0);
    assign push     = ret && !discard && !change;
    assign out_nxt  = outstanding + CW'(issue) - CW'(ret);

    assign di_read     = issue;
    assign hi_data_out = (count != '0) ? mem[rd_ptr] : '0;

    always_comb begin
        rdy = 1'b0;
        unique case (1'b1)
            is_wr:   rdy = di_ready;
            is_rd:   rdy = (count != '0);
            default: rdy = 1'b0;
        endcase
    end

    always_ff @(posedge if_clock or posedge reset) begin
        if (reset) begin
            di_ep_addr     <= '0;
            di_reg_addr    <= '0;
            di_reg_data_in <= '0;
            di_write       <= 1'b0;
            di_reset       <= 1'b0;
            hi_data_oe     <= 1'b0;
            overrun        <= 1'b0;
            len_q          <= '0;
            remaining      <= '0;
        end else begin
            di_write   <= wr_go;
            di_reset   <= change && (st_q == OP_DEVRESET);
            hi_data_oe <= is_rd;
            overrun    <= change ? 1'b0 : (overrun | wr_drop | rd_under);
            remaining  <= change ? len_q : remaining - LW'(issue);
            if (wr_go)
                di_reg_data_in <= din_q;
            if (is_ep && stb_q)
                di_ep_addr <= AW'(din_q);
            if (is_len && stb_q)
                len_q <= LW'(din_q);
            // Address advances once the write pulse or read issue has used it.
            if (is_reg && stb_q)
                di_reg_addr <= AW'(din_q);
            else if (di_write || issue)
                di_reg_addr <= di_reg_addr + AW'(AUTO_INC);
        end
    end

    always_ff @(posedge if_clock or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            discard     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            outstanding <= out_nxt;
            // Returns for reads issued before a state change are dropped.
            discard     <= (change || discard) && (out_nxt != '0);
            if (change) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + FIFO_AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + FIFO_AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge if_clock) begin
        if (push)
            mem[wr_ptr] <= di_reg_data_out;
    end

endmodule

// File: tb/tb_host_interface_burst.sv
// Randomized bench for host_interface_burst with a latency-modelling device
// and a host that pops whenever data is offered.
module tb_host_interface_burst;

    logic        if_clock;
    logic        reset;
    logic [3:0]  state;
    logic [2:0]  ctl;
    logic [15:0] hi_data_in;
    logic [15:0] hi_data_out;
    logic        hi_data_oe;
    logic        rdy;
    logic        overrun;
    logic [15:0] di_ep_addr;
    logic [15:0] di_reg_addr;
    logic [15:0] di_reg_data_in;
    logic        di_write;
    logic        di_read;
    logic        di_reset;
    logic        di_ready;
    logic        di_read_valid;
    logic [15:0] di_reg_data_out;

    int n_cmp = 0;
    int n_fail = 0;

    host_interface_burst dut (
        .if_clock        (if_clock),
        .reset           (reset),
        .state           (state),
        .ctl             (ctl),
        .hi_data_in      (hi_data_in),
        .hi_data_out     (hi_data_out),
        .hi_data_oe      (hi_data_oe),
        .rdy             (rdy),
        .overrun         (overrun),
        .di_ep_addr      (di_ep_addr),
        .di_reg_addr     (di_reg_addr),
        .di_reg_data_in  (di_reg_data_in),
        .di_write        (di_write),
        .di_read         (di_read),
        .di_reset        (di_reset),
        .di_ready        (di_ready),
        .di_read_valid   (di_read_valid),
        .di_reg_data_out (di_reg_data_out)
    );

    initial if_clock = 1'b0;
    always #5 if_clock = ~if_clock;

    // Device: returns f(address) a fixed number of cycles after each read.
    int          cyc = 0;
    int          n_issue = 0;
    int          n_write = 0;
    int          n_dreset = 0;
    int          dev_lat = 3;
    int          due_q[$];
    logic [15:0] dat_q[$];
    logic [15:0] w_addr [1024];
    logic [15:0] w_data [1024];

    function automatic logic [15:0] dev_fn(logic [15:0] a);
        logic [15:0] m;
        m = a * 16'h9E37;
        return m ^ 16'h5A5A;
    endfunction

    always @(negedge if_clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            di_read_valid   <= 1'b0;
            di_reg_data_out <= '0;
            due_q.delete();
            dat_q.delete();
        end else begin
            if (di_read) begin
                n_issue <= n_issue + 1;
                due_q.push_back(cyc + dev_lat);
                dat_q.push_back(dev_fn(di_reg_addr));
            end
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                di_read_valid   <= 1'b1;
                di_reg_data_out <= dat_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                di_read_valid <= 1'b0;
            end
        end
        if (di_write) begin
            w_addr[n_write % 1024] <= di_reg_addr;
            w_data[n_write % 1024] <= di_reg_data_in;
            n_write <= n_write + 1;
        end
        if (di_reset)
            n_dreset <= n_dreset + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1);
    end

    logic [15:0] popped[$];
    int          max_infl;

    task automatic tick(int n);
        repeat (n) @(negedge if_clock);
        #1;
    endtask

    task automatic set_state(logic [3:0] s);
        state = s;
        tick(3);
    endtask

    task automatic strobe(logic [15:0] d);
        ctl = 3'b010;
        hi_data_in = d;
        tick(1);
        ctl = 3'b000;
        tick(2);
    endtask

    // Host pops one word whenever rdy is seen, one strobe per two cycles.
    task automatic host_run(int want, int budget, output int used);
        int   s_cur;
        int   s_old;
        int   is0;
        logic last;
        is0 = n_issue;
        s_cur = 0;
        s_old = 0;
        last = 1'b0;
        max_infl = 0;
        used = 0;
        popped.delete();
        while (popped.size() < want && used < budget) begin
            if (n_issue - is0 - s_old > max_infl)
                max_infl = n_issue - is0 - s_old;
            s_old = s_cur;
            if (rdy && !last) begin
                popped.push_back(hi_data_out);
                ctl = 3'b010;
                s_cur++;
                last = 1'b1;
            end else begin
                ctl = 3'b000;
                last = 1'b0;
            end
            tick(1);
            used++;
        end
        ctl = 3'b000;
    endtask

    task automatic test_reset();
        logic [86:0] all_out;
        reset = 1'b1;
        state = 4'd0;
        ctl = 3'b000;
        hi_data_in = '0;
        di_ready = 1'b1;
        tick(3);
        all_out = {hi_data_out, hi_data_oe, rdy, overrun, di_ep_addr,
                   di_reg_addr, di_reg_data_in, di_write, di_read, di_reset};
        n_cmp++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_len_zero();
        int is0;
        is0 = n_issue;
        set_state(4'd4);
        tick(10);
        n_cmp++;
        if (n_issue - is0 !== 0) begin
            n_fail++;
            $display("FAIL len_zero_issue: got %0d reads required 0", n_issue - is0);
        end
        n_cmp++;
        if ({rdy, hi_data_oe} !== 2'b01) begin
            n_fail++;
            $display("FAIL len_zero_rdy_oe: got %b required 01", {rdy, hi_data_oe});
        end
        set_state(4'd0);
    endtask

    task automatic test_setup(logic [15:0] ep, logic [15:0] ra);
        int w0;
        int i0;
        w0 = n_write;
        i0 = n_issue;
        set_state(4'd1);
        strobe(16'hDEAD);
        strobe(ep);
        set_state(4'd2);
        strobe(ra);
        set_state(4'd0);
        n_cmp++;
        if (di_ep_addr !== ep) begin
            n_fail++;
            $display("FAIL setep: got %h required %h", di_ep_addr, ep);
        end
        n_cmp++;
        if (di_reg_addr !== ra) begin
            n_fail++;
            $display("FAIL setreg: got %h required %h", di_reg_addr, ra);
        end
        n_cmp++;
        if (n_write - w0 !== 0 || n_issue - i0 !== 0) begin
            n_fail++;
            $display("FAIL setup_pulses: got w=%0d r=%0d required 0 0",
                     n_write - w0, n_issue - i0);
        end
    endtask

    task automatic test_write(logic [15:0] base, int n, logic [15:0] d0);
        logic [15:0] d[$];
        int          w0;
        for (int i = 0; i < n; i++)
            d.push_back((d0 == 16'h0) ? 16'($urandom) : d0 + 16'(i));
        set_state(4'd2);
        strobe(base);
        set_state(4'd7);
        n_cmp++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_rdy: got %b required 1", rdy);
        end
        w0 = n_write;
        for (int i = 0; i < n; i++) begin
            ctl = 3'b010;
            hi_data_in = d[i];
            tick(1);
        end
        ctl = 3'b000;
        tick(4);
        n_cmp++;
        if (n_write - w0 !== n) begin
            n_fail++;
            $display("FAIL write_count: got %0d required %0d", n_write - w0, n);
        end
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (w_addr[(w0 + i) % 1024] !== base + 16'(i) ||
                w_data[(w0 + i) % 1024] !== d[i]) begin
                n_fail++;
                $display("FAIL write_word%0d: got %h@%h required %h@%h", i,
                         w_data[(w0 + i) % 1024], w_addr[(w0 + i) % 1024],
                         d[i], base + 16'(i));
            end
        end
        n_cmp++;
        if (di_reg_addr !== base + 16'(n) || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL write_end: got addr %h ovr %b required %h 0",
                     di_reg_addr, overrun, base + 16'(n));
        end
    endtask

    task automatic test_write_drop();
        int          w0;
        logic [15:0] a0;
        w0 = n_write;
        a0 = di_reg_addr;
        di_ready = 1'b0;
        tick(1);
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_rdy: got %b required 0", rdy);
        end
        strobe(16'hBEEF);
        tick(1);
        n_cmp++;
        if (overrun !== 1'b1 || n_write - w0 !== 0 || di_reg_addr !== a0) begin
            n_fail++;
            $display("FAIL drop: got ovr %b w %0d addr %h required 1 0 %h",
                     overrun, n_write - w0, di_reg_addr, a0);
        end
        di_ready = 1'b1;
        set_state(4'd0);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
    endtask

    task automatic test_read(logic [15:0] base, int len, int lat);
        int is0;
        int used;
        dev_lat = lat;
        set_state(4'd2);
        strobe(base);
        set_state(4'd3);
        strobe(16'(len));
        is0 = n_issue;
        state = 4'd4;
        host_run(len, 400, used);
        tick(8);
        n_cmp++;
        if (popped.size() != len) begin
            n_fail++;
            $display("FAIL read_timeout: got %0d words required %0d",
                     popped.size(), len);
        end
        n_cmp++;
        if (n_issue - is0 !== len) begin
            n_fail++;
            $display("FAIL read_issues: got %0d required %0d", n_issue - is0, len);
        end
        for (int i = 0; i < popped.size(); i++) begin
            n_cmp++;
            if (popped[i] !== dev_fn(base + 16'(i))) begin
                n_fail++;
                $display("FAIL read_word%0d: got %h required %h", i, popped[i],
                         dev_fn(base + 16'(i)));
            end
        end
        n_cmp++;
        if (max_infl > 4) begin
            n_fail++;
            $display("FAIL read_inflight: got %0d required <=4", max_infl);
        end
        n_cmp++;
        if ({rdy, overrun} !== 2'b00 || di_reg_addr !== base + 16'(len)) begin
            n_fail++;
            $display("FAIL read_end: got rdy %b ovr %b addr %h required 0 0 %h",
                     rdy, overrun, di_reg_addr, base + 16'(len));
        end
        set_state(4'd0);
    endtask

    task automatic test_stall(logic [15:0] base);
        int is0;
        int used;
        dev_lat = 2;
        set_state(4'd2);
        strobe(base);
        set_state(4'd3);
        strobe(16'd6);
        is0 = n_issue;
        state = 4'd4;
        tick(20);
        n_cmp++;
        if (n_issue - is0 !== 4 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall: got %0d reads rdy %b required 4 1",
                     n_issue - is0, rdy);
        end
        host_run(6, 300, used);
        tick(6);
        for (int i = 0; i < popped.size(); i++) begin
            n_cmp++;
            if (popped[i] !== dev_fn(base + 16'(i))) begin
                n_fail++;
                $display("FAIL stall_word%0d: got %h required %h", i, popped[i],
                         dev_fn(base + 16'(i)));
            end
        end
        n_cmp++;
        if (popped.size() != 6 || n_issue - is0 !== 6 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d/%0d ovr %b required 6/6 0",
                     popped.size(), n_issue - is0, overrun);
        end
        strobe(16'h0);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_pop_overrun: got %b required 1", overrun);
        end
        set_state(4'd0);
    endtask

    task automatic test_stale(logic [15:0] base);
        int is0;
        int used;
        dev_lat = 12;
        set_state(4'd2);
        strobe(base);
        set_state(4'd3);
        strobe(16'd8);
        is0 = n_issue;
        state = 4'd4;
        tick(8);
        n_cmp++;
        if (n_issue - is0 !== 4) begin
            n_fail++;
            $display("FAIL stale_first: got %0d reads required 4", n_issue - is0);
        end
        state = 4'd0;
        tick(3);
        state = 4'd4;
        host_run(8, 500, used);
        tick(16);
        n_cmp++;
        if (popped.size() != 8) begin
            n_fail++;
            $display("FAIL stale_timeout: got %0d words required 8", popped.size());
        end
        for (int i = 0; i < popped.size(); i++) begin
            n_cmp++;
            if (popped[i] !== dev_fn(base + 16'(4 + i))) begin
                n_fail++;
                $display("FAIL stale_word%0d: got %h required %h", i, popped[i],
                         dev_fn(base + 16'(4 + i)));
            end
        end
        set_state(4'd0);
        dev_lat = 3;
    endtask

    task automatic test_reset_mid_and_devreset();
        logic [86:0] all_out;
        int          d0;
        set_state(4'd2);
        strobe(16'h0100);
        set_state(4'd7);
        ctl = 3'b010;
        hi_data_in = 16'h1111;
        tick(2);
        reset = 1'b1;
        #1;
        all_out = {hi_data_out, hi_data_oe, rdy, overrun, di_ep_addr,
                   di_reg_addr, di_reg_data_in, di_write, di_read, di_reset};
        n_cmp++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h required 0", all_out);
        end
        tick(2);
        ctl = 3'b000;
        state = 4'd0;
        reset = 1'b0;
        tick(3);
        d0 = n_dreset;
        set_state(4'd5);
        tick(6);
        n_cmp++;
        if (n_dreset - d0 !== 1) begin
            n_fail++;
            $display("FAIL devreset: got %0d pulse cycles required 1", n_dreset - d0);
        end
        set_state(4'd0);
    endtask

    initial begin
        test_reset();
        test_len_zero();
        test_setup(16'h0012, 16'h0040);
        test_setup(16'($urandom), 16'($urandom));
        test_write(16'h0040, 3, 16'h00A1);
        test_write(16'($urandom), 5, 16'h0000);
        test_write_drop();
        test_read(16'h0040, 6, 3);
        test_read(16'hFFFD, 7, 1);
        for (int k = 0; k < 4; k++)
            test_read(16'($urandom), $urandom_range(1, 10), $urandom_range(1, 6));
        test_stall(16'($urandom));
        test_stale(16'($urandom));
        test_reset_mid_and_devreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
